combined_radix: RTL and testbench
=================================

COMBINED_RADIX -- requirements
Module: combined_radix

Interface
REQ-001 SHALL have parameter WIDTH, default 18, data width of all data ports.
REQ-002 SHALL have parameter Q, default 65537, prime modulus; the reduction datapath SHALL rely on 2^16 ≡ -1 mod Q.
REQ-003 SHALL have port clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports input_1..input_8  in  WIDTH signed  coefficients, bit-reversed order: input_(j+1) = x[br3(j)].
REQ-006 SHALL have ports psi_1..psi_8  in  WIDTH signed  per-lane psi multipliers; the NTT convention is psi_(j+1) = psi^br3(j).
REQ-007 SHALL have ports w_0_8..w_3_8  in  WIDTH signed  twiddles omega^k, k = 0..3, where omega = psi^2.
REQ-008 SHALL have port select_mode  in  2  00 = four radix-2, 01 = two radix-4, 10 = one radix-8, 11 = treated as 10.
REQ-009 SHALL have port NTT_INTT_mode  in  1  0 = forward NTT, 1 = inverse.
REQ-010 SHALL have port in_valid  in  1  input sample qualifier.
REQ-011 SHALL have port out_valid  out  1  output qualifier.
REQ-012 SHALL have ports output_1..output_8  out  WIDTH signed  results, registered, always in [0, Q-1].

Function
REQ-013 Each data and twiddle input SHALL be reduced into [0, Q-1] before use; negative two's-complement values SHALL map to their mod-Q residue.
REQ-014 Modular multiply SHALL be a full 17x17 product folded with 2^16 ≡ -1, then a final conditional correction.
REQ-015 Modular add and subtract SHALL each be fully reduced.
REQ-016 NTT mode, stage 0: lane j SHALL be y_j = input_j*psi_j mod Q.
REQ-017 Radix-8 (mode 10): three DIT stages SHALL run on y using w_0_8..w_3_8, giving output_(k+1) = sum_n y[n]*omega^(nk) mod Q in natural order, where y[n] is the lane holding x[n].
REQ-018 Radix-4 (mode 01): lanes 1-4 and lanes 5-8 SHALL each be an independent 4-point DIT using w_0_8 and w_2_8 as the 4th-root twiddles; results SHALL appear in natural order on the same lane group.
REQ-019 Radix-2 (mode 00): pairs (1,2), (3,4), (5,6) and (7,8) SHALL each produce out_a = y_a + y_b and out_b = y_a - y_b mod Q.
REQ-020 INTT mode: psi premultiply SHALL be skipped; the same butterfly network SHALL run with the supplied w ports, which carry the inverse twiddles.
REQ-021 INTT mode: output_j SHALL be T_j*psi_j mod Q; there SHALL be no 1/N scaling.
REQ-022 Latency SHALL be 1 cycle: inputs sampled on a clk edge with in_valid=1 SHALL appear on the outputs at that edge, with out_valid=1 for one cycle.
REQ-023 Back-to-back in_valid SHALL give full throughput, one result per cycle.
REQ-024 With in_valid=0: outputs SHALL hold and out_valid SHALL be 0.
REQ-025 Mode inputs SHALL be sampled with data; a mode change SHALL affect only the samples taken with it.

Reset
REQ-026 rst_n=0 SHALL immediately clear out_valid, all output_* and any pipeline registers to 0, including mid-operation.
REQ-027 The first valid output after rst_n rises SHALL come from the first in_valid sample taken after release.

Configuration
REQ-028 Macro COMBINED_RADIX_PIPE_EN defined: a register SHALL sit after stage 0 and after the middle butterfly stage, giving latency 3 cycles with full throughput; out_valid SHALL track the pipeline.
REQ-029 Macro COMBINED_RADIX_PIPE_EN undefined: latency SHALL be 1 cycle per REQ-022.

Verification
REQ-030 Forward radix-8: inputs 0,4,2,6,1,5,3,7; psi 1,256,16,4096,4,1024,64,16384; w 1,16,256,4096; mode 10; NTT_INTT_mode 0 -> output_1=14562, output_5=36702, out_valid=1 after the latency.
REQ-031 Radix-2: input_1=3, input_2=5, psi all 1 -> output_1=8, output_2=65535.
REQ-032 Radix-2 range check: input_1=input_2=65536, psi_1=65536, psi_2=1 -> output_1=0, output_2=2.
REQ-033 Radix-4: lanes 1-4 all 1, psi all 1, w_2_8=256 -> output_1..4 = 4,0,0,0.
REQ-034 Radix-8 round trip: forward result fed back in INTT mode with inverse twiddles, then scaled by 8^-1 externally -> original vector.
REQ-035 Reset: rst_n low mid-stream, with and without COMBINED_RADIX_PIPE_EN -> outputs and out_valid 0 immediately; valid results resume after the latency.

Source files
------------

// File: rtl/combined_radix.sv
// Combined radix-2/4/8 NTT/INTT butterfly network over Q = 65537, using 2^16 == -1 mod Q.
// Optional macro COMBINED_RADIX_PIPE_EN registers stage 0 and the middle stage (latency 3).
module combined_radix #(
  parameter int WIDTH = 18,
  parameter int Q     = 65537
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] input_1,
  input  logic signed [WIDTH-1:0] input_2,
  input  logic signed [WIDTH-1:0] input_3,
  input  logic signed [WIDTH-1:0] input_4,
  input  logic signed [WIDTH-1:0] input_5,
  input  logic signed [WIDTH-1:0] input_6,
  input  logic signed [WIDTH-1:0] input_7,
  input  logic signed [WIDTH-1:0] input_8,
  input  logic signed [WIDTH-1:0] psi_1,
  input  logic signed [WIDTH-1:0] psi_2,
  input  logic signed [WIDTH-1:0] psi_3,
  input  logic signed [WIDTH-1:0] psi_4,
  input  logic signed [WIDTH-1:0] psi_5,
  input  logic signed [WIDTH-1:0] psi_6,
  input  logic signed [WIDTH-1:0] psi_7,
  input  logic signed [WIDTH-1:0] psi_8,
  input  logic signed [WIDTH-1:0] w_0_8,
  input  logic signed [WIDTH-1:0] w_1_8,
  input  logic signed [WIDTH-1:0] w_2_8,
  input  logic signed [WIDTH-1:0] w_3_8,
  input  logic [1:0]              select_mode,
  input  logic                    NTT_INTT_mode,
  input  logic                    in_valid,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] output_1,
  output logic signed [WIDTH-1:0] output_2,
  output logic signed [WIDTH-1:0] output_3,
  output logic signed [WIDTH-1:0] output_4,
  output logic signed [WIDTH-1:0] output_5,
  output logic signed [WIDTH-1:0] output_6,
  output logic signed [WIDTH-1:0] output_7,
  output logic signed [WIDTH-1:0] output_8
);

  typedef logic [16:0] res_t;

  localparam logic [17:0]             Q18    = 18'(Q);
  localparam logic signed [18:0]      Q19    = 19'(Q);
  localparam logic signed [WIDTH+1:0] QW     = (WIDTH+2)'(Q);
  localparam logic signed [WIDTH+1:0] TWO_QW = (WIDTH+2)'(2 * Q);

  // One +2Q and one -Q step cover the full signed input range for WIDTH <= 18.
  function automatic res_t red_in(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH+1:0] t;
    t = {{2{v[WIDTH-1]}}, v};
    if (t[WIDTH+1]) t = t + TWO_QW;
    if (t >= QW) t = t - QW;
    return t[16:0];
  endfunction

  function automatic res_t mod_mul(input res_t a, input res_t b);
    logic [32:0]        p;
    logic signed [18:0] r;
    p = 33'(a) * 33'(b);
    r = $signed({3'b000, p[15:0]}) - $signed({2'b00, p[32:16]});
    if (r[18]) r = r + Q19;
    return r[16:0];
  endfunction

  function automatic res_t mod_add(input res_t a, input res_t b);
    logic [17:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= Q18) s = s - Q18;
    return s[16:0];
  endfunction

  function automatic res_t mod_sub(input res_t a, input res_t b);
    logic signed [18:0] d;
    d = $signed({2'b00, a}) - $signed({2'b00, b});
    if (d[18]) d = d + Q19;
    return d[16:0];
  endfunction

  logic signed [WIDTH-1:0] in_a  [8];
  logic signed [WIDTH-1:0] psi_a [8];
  logic signed [WIDTH-1:0] w_a   [4];

  assign in_a[0] = input_1;  assign in_a[1] = input_2;
  assign in_a[2] = input_3;  assign in_a[3] = input_4;
  assign in_a[4] = input_5;  assign in_a[5] = input_6;
  assign in_a[6] = input_7;  assign in_a[7] = input_8;
  assign psi_a[0] = psi_1;   assign psi_a[1] = psi_2;
  assign psi_a[2] = psi_3;   assign psi_a[3] = psi_4;
  assign psi_a[4] = psi_5;   assign psi_a[5] = psi_6;
  assign psi_a[6] = psi_7;   assign psi_a[7] = psi_8;
  assign w_a[0] = w_0_8;     assign w_a[1] = w_1_8;
  assign w_a[2] = w_2_8;     assign w_a[3] = w_3_8;

  // Stage 0: reduce everything; forward mode premultiplies by psi.
  res_t y_d [8];
  res_t p_d [8];
  res_t w_d [4];

  always_comb begin
    for (int j = 0; j < 8; j++) begin
      p_d[j] = red_in(psi_a[j]);
      y_d[j] = NTT_INTT_mode ? red_in(in_a[j])
                             : mod_mul(red_in(in_a[j]), red_in(psi_a[j]));
    end
    for (int k = 0; k < 4; k++) w_d[k] = red_in(w_a[k]);
  end

  res_t       y1 [8];
  res_t       p1 [8];
  res_t       w1 [4];
  logic [1:0] mode1;
  logic       intt1;
  logic       v1;

`ifdef COMBINED_RADIX_PIPE_EN
  res_t       y0_q [8];
  res_t       p0_q [8];
  res_t       w0_q [4];
  logic [1:0] mode0_q;
  logic       intt0_q;
  logic       v0_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 8; j++) begin
        y0_q[j] <= '0;
        p0_q[j] <= '0;
      end
      for (int k = 0; k < 4; k++) w0_q[k] <= '0;
      mode0_q <= '0;
      intt0_q <= 1'b0;
      v0_q    <= 1'b0;
    end else begin
      v0_q <= in_valid;
      if (in_valid) begin
        y0_q    <= y_d;
        p0_q    <= p_d;
        w0_q    <= w_d;
        mode0_q <= select_mode;
        intt0_q <= NTT_INTT_mode;
      end
    end
  end

  assign y1    = y0_q;
  assign p1    = p0_q;
  assign w1    = w0_q;
  assign mode1 = mode0_q;
  assign intt1 = intt0_q;
  assign v1    = v0_q;
`else
  assign y1    = y_d;
  assign p1    = p_d;
  assign w1    = w_d;
  assign mode1 = select_mode;
  assign intt1 = NTT_INTT_mode;
  assign v1    = in_valid;
`endif

  // Stages 1-2: span-1 butterflies, then span-2 with w0/w2 (skipped in radix-2).
  res_t s1   [8];
  res_t s2_d [8];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s1[2*i]   = mod_add(y1[2*i], y1[2*i+1]);
      s1[2*i+1] = mod_sub(y1[2*i], y1[2*i+1]);
    end
  end

  always_comb begin
    res_t t0;
    res_t t1;
    t0   = '0;
    t1   = '0;
    s2_d = s1;
    if (mode1 != 2'b00) begin
      for (int g = 0; g < 2; g++) begin
        t0 = mod_mul(s1[4*g+2], w1[0]);
        t1 = mod_mul(s1[4*g+3], w1[2]);
        s2_d[4*g]   = mod_add(s1[4*g],   t0);
        s2_d[4*g+2] = mod_sub(s1[4*g],   t0);
        s2_d[4*g+1] = mod_add(s1[4*g+1], t1);
        s2_d[4*g+3] = mod_sub(s1[4*g+1], t1);
      end
    end
  end

  res_t s2 [8];
  res_t p2 [8];
  res_t w2 [4];
  logic r8_2;
  logic intt2;
  logic v2;

`ifdef COMBINED_RADIX_PIPE_EN
  res_t s2_q [8];
  res_t p1_q [8];
  res_t w1_q [4];
  logic r8_q;
  logic intt1_q;
  logic v1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 8; j++) begin
        s2_q[j] <= '0;
        p1_q[j] <= '0;
      end
      for (int k = 0; k < 4; k++) w1_q[k] <= '0;
      r8_q    <= 1'b0;
      intt1_q <= 1'b0;
      v1_q    <= 1'b0;
    end else begin
      v1_q <= v1;
      if (v1) begin
        s2_q    <= s2_d;
        p1_q    <= p1;
        w1_q    <= w1;
        r8_q    <= mode1[1];
        intt1_q <= intt1;
      end
    end
  end

  assign s2    = s2_q;
  assign p2    = p1_q;
  assign w2    = w1_q;
  assign r8_2  = r8_q;
  assign intt2 = intt1_q;
  assign v2    = v1_q;
`else
  assign s2    = s2_d;
  assign p2    = p1;
  assign w2    = w1;
  assign r8_2  = mode1[1];
  assign intt2 = intt1;
  assign v2    = v1;
`endif

  // Stage 3 (radix-8 only), then the inverse-mode psi post-multiply.
  res_t s3    [8];
  res_t fin_d [8];

  always_comb begin
    res_t t;
    t  = '0;
    s3 = s2;
    if (r8_2) begin
      for (int j = 0; j < 4; j++) begin
        t       = mod_mul(s2[j+4], w2[j]);
        s3[j]   = mod_add(s2[j], t);
        s3[j+4] = mod_sub(s2[j], t);
      end
    end
  end

  always_comb begin
    for (int j = 0; j < 8; j++)
      fin_d[j] = intt2 ? mod_mul(s3[j], p2[j]) : s3[j];
  end

  logic signed [WIDTH-1:0] out_q [8];
  logic                    out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 8; j++) out_q[j] <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= v2;
      if (v2) begin
        for (int j = 0; j < 8; j++) out_q[j] <= WIDTH'(fin_d[j]);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign output_1  = out_q[0];
  assign output_2  = out_q[1];
  assign output_3  = out_q[2];
  assign output_4  = out_q[3];
  assign output_5  = out_q[4];
  assign output_6  = out_q[5];
  assign output_7  = out_q[6];
  assign output_8  = out_q[7];

endmodule

// File: tb/tb_combined_radix.sv
// Bench for combined_radix: directed vectors plus random traffic checked against a DFT-sum model.
module tb_combined_radix;

  localparam int     W = 18;
  localparam longint Q = 65537;
`ifdef COMBINED_RADIX_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [1:0]          select_mode;
  logic                intt;
  logic                in_valid;
  logic                out_valid;
  logic signed [W-1:0] in_v  [8];
  logic signed [W-1:0] psi_v [8];
  logic signed [W-1:0] w_v   [4];
  logic signed [W-1:0] o1, o2, o3, o4, o5, o6, o7, o8;
  logic signed [W-1:0] out_v [8];

  always_comb begin
    out_v[0] = o1; out_v[1] = o2; out_v[2] = o3; out_v[3] = o4;
    out_v[4] = o5; out_v[5] = o6; out_v[6] = o7; out_v[7] = o8;
  end

  combined_radix #(.WIDTH(W), .Q(65537)) dut (
    .clk(clk), .rst_n(rst_n),
    .input_1(in_v[0]), .input_2(in_v[1]), .input_3(in_v[2]), .input_4(in_v[3]),
    .input_5(in_v[4]), .input_6(in_v[5]), .input_7(in_v[6]), .input_8(in_v[7]),
    .psi_1(psi_v[0]), .psi_2(psi_v[1]), .psi_3(psi_v[2]), .psi_4(psi_v[3]),
    .psi_5(psi_v[4]), .psi_6(psi_v[5]), .psi_7(psi_v[6]), .psi_8(psi_v[7]),
    .w_0_8(w_v[0]), .w_1_8(w_v[1]), .w_2_8(w_v[2]), .w_3_8(w_v[3]),
    .select_mode(select_mode), .NTT_INTT_mode(intt), .in_valid(in_valid),
    .out_valid(out_valid),
    .output_1(o1), .output_2(o2), .output_3(o3), .output_4(o4),
    .output_5(o5), .output_6(o6), .output_7(o7), .output_8(o8)
  );

  typedef struct {
    int     due;
    longint o [8];
  } exp_t;

  exp_t   sbq [$];
  longint held [8];
  longint cur_in [8];
  longint cur_psi [8];
  longint cur_om;
  longint exp_o [8];
  longint fwd [8];
  longint roots [4] = '{16, 4096, 65521, 61441};
  int     cyc = 0;
  int     n_assert = 0;
  int     n_fail = 0;

  function automatic longint md(input longint v);
    return ((v % Q) + Q) % Q;
  endfunction

  function automatic longint mpow(input longint b, input int e);
    longint r;
    r = 1;
    for (int i = 0; i < e; i++) r = md(r * b);
    return r;
  endfunction

  function automatic int br3(input int j);
    return ((j & 1) << 2) | (j & 2) | ((j >> 2) & 1);
  endfunction

  function automatic int br2(input int j);
    return ((j & 1) << 1) | ((j >> 1) & 1);
  endfunction

  // Expected result straight from the transform definitions.
  task automatic compute(input int mode, input bit inv);
    longint y [8];
    longint t [8];
    longint acc;
    for (int j = 0; j < 8; j++)
      y[j] = inv ? md(cur_in[j]) : md(md(cur_in[j]) * md(cur_psi[j]));
    if (mode >= 2) begin
      for (int k = 0; k < 8; k++) begin
        acc = 0;
        for (int n = 0; n < 8; n++) acc = md(acc + y[br3(n)] * mpow(cur_om, (n * k) % 8));
        t[k] = acc;
      end
    end else if (mode == 1) begin
      for (int g = 0; g < 2; g++)
        for (int k = 0; k < 4; k++) begin
          acc = 0;
          for (int m = 0; m < 4; m++)
            acc = md(acc + y[4*g + br2(m)] * mpow(cur_om, 2 * ((m * k) % 4)));
          t[4*g + k] = acc;
        end
    end else begin
      for (int i = 0; i < 4; i++) begin
        t[2*i]   = md(y[2*i] + y[2*i+1]);
        t[2*i+1] = md(y[2*i] - y[2*i+1]);
      end
    end
    for (int j = 0; j < 8; j++) exp_o[j] = inv ? md(t[j] * md(cur_psi[j])) : t[j];
  endtask

  task automatic send(input int mode, input bit inv, input bit neg_w);
    exp_t   e;
    longint wk;
    compute(mode, inv);
    for (int j = 0; j < 8; j++) begin
      in_v[j]  = W'(cur_in[j]);
      psi_v[j] = W'(cur_psi[j]);
    end
    for (int k = 0; k < 4; k++) begin
      wk = mpow(cur_om, k);
      if (neg_w && (k % 2 == 1)) wk = wk - Q;
      w_v[k] = W'(wk);
    end
    select_mode = 2'(mode);
    intt        = inv;
    in_valid    = 1'b1;
    e.due = cyc + LAT;
    e.o   = exp_o;
    sbq.push_back(e);
  endtask

  task automatic rand_vec();
    for (int j = 0; j < 8; j++) begin
      cur_in[j]  = longint'($urandom_range(0, 262143)) - 131072;
      cur_psi[j] = longint'($urandom_range(0, 262143)) - 131072;
    end
    cur_om = roots[$urandom_range(0, 3)];
  endtask

  task automatic check_out();
    bit ev;
    ev = (sbq.size() > 0) && (sbq[0].due == cyc);
    n_assert++;
    assert (out_valid === ev) else begin
      n_fail++;
      $error("FAIL out_valid cyc=%0d observed=%b expected=%b", cyc, out_valid, ev);
    end
    if (ev) begin
      exp_t e;
      e = sbq.pop_front();
      for (int i = 0; i < 8; i++) held[i] = e.o[i];
    end
    for (int i = 0; i < 8; i++) begin
      n_assert++;
      assert (out_v[i] === W'(held[i])) else begin
        n_fail++;
        $error("FAIL output_%0d cyc=%0d observed=%0d expected=%0d", i + 1, cyc, out_v[i], held[i]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_out();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic chk(input string tag, input longint got, input longint expv);
    n_assert++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, expv);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    select_mode = 2'b00;
    intt        = 1'b0;
    for (int j = 0; j < 8; j++) begin
      in_v[j] = '0; psi_v[j] = '0; held[j] = 0;
    end
    for (int k = 0; k < 4; k++) w_v[k] = '0;

    repeat (3) step();
    #2 rst_n = 1'b1;
    idle(2);

    // Forward radix-8 reference vector.
    cur_in  = '{0, 4, 2, 6, 1, 5, 3, 7};
    cur_psi = '{1, 256, 16, 4096, 4, 1024, 64, 16384};
    cur_om  = 16;
    send(2, 1'b0, 1'b0);
    fwd = exp_o;
    step();
    idle(LAT + 1);
    chk("r8_output_1", longint'(out_v[0]), 14562);
    chk("r8_output_5", longint'(out_v[4]), 36702);

    send(3, 1'b0, 1'b0);
    step();
    idle(LAT + 1);
    chk("mode11_output_1", longint'(out_v[0]), 14562);

    // Inverse round trip: bit-reversed spectrum, inverse twiddles, psi^-j, then * 8^-1.
    for (int j = 0; j < 8; j++) begin
      cur_in[j]  = fwd[br3(j)];
      cur_psi[j] = mpow(49153, j);
    end
    cur_om = 61441;
    send(2, 1'b1, 1'b0);
    step();
    idle(LAT + 1);
    for (int n = 0; n < 8; n++)
      chk($sformatf("roundtrip_x%0d", n), md(longint'(out_v[n]) * 57345), longint'(n));

    cur_in  = '{3, 5, 0, 0, 0, 0, 0, 0};
    cur_psi = '{1, 1, 1, 1, 1, 1, 1, 1};
    cur_om  = 16;
    send(0, 1'b0, 1'b0);
    step();
    idle(LAT + 1);
    chk("r2_output_1", longint'(out_v[0]), 8);
    chk("r2_output_2", longint'(out_v[1]), 65535);

    cur_in  = '{65536, 65536, 0, 0, 0, 0, 0, 0};
    cur_psi = '{65536, 1, 1, 1, 1, 1, 1, 1};
    send(0, 1'b0, 1'b0);
    step();
    idle(LAT + 1);
    chk("r2_range_output_1", longint'(out_v[0]), 0);
    chk("r2_range_output_2", longint'(out_v[1]), 2);

    cur_in  = '{1, 1, 1, 1, 0, 0, 0, 0};
    cur_psi = '{1, 1, 1, 1, 1, 1, 1, 1};
    send(1, 1'b0, 1'b0);
    step();
    idle(LAT + 1);
    chk("r4_output_1", longint'(out_v[0]), 4);
    chk("r4_output_2", longint'(out_v[1]), 0);
    chk("r4_output_3", longint'(out_v[2]), 0);
    chk("r4_output_4", longint'(out_v[3]), 0);

    // Random traffic with mixed modes, per-sample mode changes and gaps.
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 3) != 0) begin
        rand_vec();
        send(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    idle(LAT + 1);
    chk("random_drained", longint'(sbq.size()), 0);

    // Reset asserted mid-stream.
    for (int i = 0; i < 3; i++) begin
      rand_vec();
      send(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
      step();
    end
    rand_vec();
    send(2, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", longint'(out_valid), 0);
    for (int i = 0; i < 8; i++) chk($sformatf("reset_output_%0d", i + 1), longint'(out_v[i]), 0);
    sbq.delete();
    for (int i = 0; i < 8; i++) held[i] = 0;
    step();
    step();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    idle(2);
    rand_vec();
    send(2, 1'b0, 1'b0);
    step();
    rand_vec();
    send(1, 1'b1, 1'b0);
    step();
    idle(LAT + 1);
    chk("post_reset_drained", longint'(sbq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
